instr_fetch_queue: RTL

Parametrised instruction-fetch stage with a decoupling instruction queue between the program counter and decode. It issues sequential fetches to a synchronous single-cycle instruction memory, buffers returned words with their PC in a FIFO, and hands them to decode over a valid/ready handshake. Backpressure replaces the single-bit hazard freeze. An EX-stage redirect flushes the queue and discards any in-flight fetch.

---
 rtl/instr_fetch_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//
// Instruction-fetch stage with a decoupling queue between the program counter
// and decode. Sequential fetches go to a synchronous single-cycle instruction
// memory. Each returned word is stored in a small FIFO together with its PC and
// is offered to decode over a valid/ready handshake. An EX-stage redirect
// flushes the queue and drops any response still in flight.
//
// Parameters:
//   XLEN      PC / instruction width
//   FQ_DEPTH  queue entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset (word aligned)
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   imem_req        fetch request this cycle
//   imem_addr       byte address of the request (always equals the fetch PC)
//   imem_rdata      instruction word, valid the cycle after a request
//   redirect_valid  taken branch/jump from EX
//   redirect_pc     redirect target (bits [1:0] ignored)
//   out_valid       queue head valid for decode
//   out_ready       decode accepts the head
//   out_instr       head instruction
//   out_pc          head PC
//   out_pc4         head PC + 4 (wraps)
//   fq_count        occupied queue entries (registered)
module instr_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [XLEN-1:0]             imem_addr,
  input  logic [XLEN-1:0]             imem_rdata,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_instr,
  output logic [XLEN-1:0]             out_pc,
  output logic [XLEN-1:0]             out_pc4,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);

  // Architectural state
  logic [XLEN-1:0] fpc_reg;
  logic [XLEN-1:0] req_pc_reg;     // PC of the request whose data arrives this cycle
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            inflight_reg;
  logic            discard_reg;

  logic [XLEN-1:0] instr_mem [FQ_DEPTH];
  logic [XLEN-1:0] pc_mem    [FQ_DEPTH];

  logic            deq;
  logic            enq;
  logic            issue;
  logic [CW:0]     occupancy;

  // Low address bits of the redirect target are discarded by design.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Head is hidden during a redirect so no wrong-path handshake can occur.
  assign out_valid = (count_reg != '0) & ~redirect_valid;
  assign deq       = out_valid & out_ready;

  // Entries held plus the one that may land next edge, minus the one leaving
  // now. Issuing only while this is below depth guarantees the response always
  // has a free slot, so the queue cannot overflow.
  assign occupancy = {1'b0, count_reg} + (CW+1)'(inflight_reg) - (CW+1)'(deq);
  assign issue     = ~rst & ~redirect_valid & (occupancy < DEPTH_W);

  // Redirect wins over the arriving response; discard drops a response whose
  // request was issued before a flush.
  assign enq = inflight_reg & ~discard_reg & ~redirect_valid;

  assign imem_req  = issue;
  assign imem_addr = fpc_reg;

  assign out_instr = instr_mem[rd_ptr_reg];
  assign out_pc    = pc_mem[rd_ptr_reg];
  assign out_pc4   = out_pc + XLEN'(4);
  assign fq_count  = count_reg;

  // Queue storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]    <= req_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_reg      <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      discard_reg  <= 1'b0;
    end else if (redirect_valid) begin
      fpc_reg      <= {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      discard_reg  <= inflight_reg;
      inflight_reg <= 1'b0;
    end else begin
      discard_reg  <= 1'b0;
      inflight_reg <= issue;
      if (issue) begin
        fpc_reg    <= fpc_reg + XLEN'(4);
        req_pc_reg <= fpc_reg;
      end
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule
